// File: rtl/psk_symbol_mapper.sv
// psk_symbol_mapper: BPSK/QPSK symbol mapper holding each symbol on the DAC for SPS enabled samples
module psk_symbol_mapper #(
  parameter int O_WIDTH = 12,
  parameter int SPS     = 8,
  parameter int AMP     = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_enable,
  input  logic [1:0]                bits_in,
  input  logic                      bits_valid,
  output logic                      bits_ready,
  input  logic                      is_bpsk,
  output logic signed [O_WIDTH-1:0] DAC_I,
  output logic signed [O_WIDTH-1:0] DAC_Q,
  output logic                      is_bpsk_out,
  output logic                      sym_strobe,
  output logic                      underrun
);
  localparam int CW = SPS > 1 ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);
  localparam logic signed [O_WIDTH-1:0] AP = O_WIDTH'(AMP);
  localparam logic signed [O_WIDTH-1:0] AN = -AP;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [O_WIDTH-1:0] i_q, i_d, q_q, q_d, map_i, map_q;
  logic bpsk_q, bpsk_d, strobe_q, strobe_d, under_q, under_d, xfer;
  assign bits_ready = clk_enable & rst_n & (state_q == IDLE || cnt_q == LAST);
  assign xfer = bits_valid & bits_ready;
  assign map_i = (is_bpsk ? bits_in[0] : bits_in[1]) ? AN : AP;
  assign map_q = is_bpsk ? '0 : (bits_in[0] ? AN : AP);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i_d      = i_q;
    q_d      = q_q;
    bpsk_d   = bpsk_q;
    strobe_d = 1'b0;
    under_d  = 1'b0;
    if (xfer) begin
      state_d  = RUN;
      cnt_d    = '0;
      i_d      = map_i;
      q_d      = map_q;
      bpsk_d   = is_bpsk;
      strobe_d = 1'b1;
    end else if (clk_enable && state_q == RUN) begin
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        i_d     = '0;
        q_d     = '0;
        bpsk_d  = 1'b0;
        under_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      i_q      <= '0;
      q_q      <= '0;
      bpsk_q   <= 1'b0;
      strobe_q <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      i_q      <= i_d;
      q_q      <= q_d;
      bpsk_q   <= bpsk_d;
      strobe_q <= strobe_d;
      under_q  <= under_d;
    end
  end
  assign DAC_I       = i_q;
  assign DAC_Q       = q_q;
  assign is_bpsk_out = bpsk_q;
  assign sym_strobe  = strobe_q;
  assign underrun    = under_q;
endmodule

// File: tb/tb_psk_symbol_mapper.sv
// tb_psk_symbol_mapper: directed checks of the PSK mapper at SPS=8 and SPS=1
module tb_psk_symbol_mapper;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, valid = 1'b0, bpsk = 1'b0;
  logic [1:0] bits = 2'b00;
  logic rdy, bpsk_o, strb, und;
  logic signed [11:0] di, dq;
  logic en1 = 1'b0, valid1 = 1'b0, bpsk1 = 1'b0;
  logic [1:0] bits1 = 2'b00;
  logic rdy1, bpsk_o1, strb1, und1;
  logic signed [11:0] di1, dq1;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  psk_symbol_mapper #(.O_WIDTH(12), .SPS(8), .AMP(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(en), .bits_in(bits), .bits_valid(valid),
    .bits_ready(rdy), .is_bpsk(bpsk), .DAC_I(di), .DAC_Q(dq), .is_bpsk_out(bpsk_o),
    .sym_strobe(strb), .underrun(und)
  );
  psk_symbol_mapper #(.O_WIDTH(12), .SPS(1), .AMP(1024)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clk_enable(en1), .bits_in(bits1), .bits_valid(valid1),
    .bits_ready(rdy1), .is_bpsk(bpsk1), .DAC_I(di1), .DAC_Q(dq1), .is_bpsk_out(bpsk_o1),
    .sym_strobe(strb1), .underrun(und1)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input int ei, input int eq, input int eb, input int es, input int eu);
    chk({tag, ".i"}, int'(di), ei);
    chk({tag, ".q"}, int'(dq), eq);
    chk({tag, ".bpsk"}, int'(bpsk_o), eb);
    chk({tag, ".strobe"}, int'(strb), es);
    chk({tag, ".underrun"}, int'(und), eu);
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  function automatic int exp_i(input logic b, input logic [1:0] x);
    return (b ? x[0] : x[1]) ? -1024 : 1024;
  endfunction
  function automatic int exp_q(input logic b, input logic [1:0] x);
    return b ? 0 : (x[0] ? -1024 : 1024);
  endfunction
  initial begin
    logic pb;
    logic [1:0] px;
    repeat (2) cyc;
    outs("rst", 0, 0, 0, 0, 0);
    chk("rst.rdy", int'(rdy), 0);
    rst_n = 1'b1;
    en = 1'b1;
    #1 chk("idle.rdy", int'(rdy), 1);
    bpsk = 1'b1; bits = 2'b01; valid = 1'b1;
    cyc;
    valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      outs($sformatf("bpsk%0d", k), -1024, 0, 1, int'(k == 0), 0);
      chk($sformatf("bpsk%0d.rdy", k), int'(rdy), int'(k == 7));
      cyc;
    end
    outs("bpsk.end", 0, 0, 0, 0, 1);
    cyc;
    outs("bpsk.idle", 0, 0, 0, 0, 0);
    bpsk = 1'b0; bits = 2'b00; valid = 1'b1;
    cyc;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 8; k++) begin
        outs($sformatf("qpsk%0d_%0d", s, k), s[1] ? -1024 : 1024, s[0] ? -1024 : 1024, 0, int'(k == 0), 0);
        if (k == 0) begin
          bits = 2'(s + 1);
          valid = s < 3;
        end
        cyc;
      end
    outs("qpsk.end", 0, 0, 0, 0, 1);
    bits = 2'b10; valid = 1'b1; en = 1'b1;
    cyc;
    for (int s = 0; s < 2; s++)
      for (int j = 0; j < 16; j++) begin
        outs($sformatf("alt%0d_%0d", s, j), s == 0 ? -1024 : 1024, s == 0 ? 1024 : -1024, 0, int'(j == 0), 0);
        en = j[0];
        if (j == 0) begin
          bits = 2'b01;
          valid = s == 0;
        end
        #1 chk($sformatf("alt%0d_%0d.rdy", s, j), int'(rdy), int'(j == 15));
        cyc;
      end
    outs("alt.end", 0, 0, 0, 0, 1);
    en = 1'b1; bpsk = 1'b0; bits = 2'b11; valid = 1'b1;
    cyc;
    valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      outs($sformatf("tog%0d", k), -1024, -1024, 0, int'(k == 0), 0);
      bpsk = ~bpsk;
      bits = ~bits;
      cyc;
    end
    outs("tog.end", 0, 0, 0, 0, 1);
    bpsk = 1'b0; bits = 2'b00; valid = 1'b1;
    cyc;
    valid = 1'b0;
    repeat (3) cyc;
    outs("mid", 1024, 1024, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    outs("arst", 0, 0, 0, 0, 0);
    chk("arst.rdy", int'(rdy), 0);
    repeat (2) cyc;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc;
      outs($sformatf("rel%0d", k), 0, 0, 0, 0, 0);
    end
    rst_n = 1'b0;
    cyc;
    rst_n = 1'b1; bits = 2'b01; valid = 1'b1;
    cyc;
    outs("first", 1024, -1024, 0, 1, 0);
    valid = 1'b0;
    repeat (8) cyc;
    outs("first.end", 0, 0, 0, 0, 1);
    en1 = 1'b1; valid1 = 1'b1;
    bpsk1 = 1'($urandom_range(0, 1)); bits1 = 2'($urandom_range(0, 3));
    for (int k = 0; k < 12; k++) begin
      pb = bpsk1;
      px = bits1;
      #1 chk("s1.rdy_pre", int'(rdy1), 1);
      cyc;
      chk($sformatf("s1_%0d.i", k), int'(di1), exp_i(pb, px));
      chk($sformatf("s1_%0d.q", k), int'(dq1), exp_q(pb, px));
      chk($sformatf("s1_%0d.bpsk", k), int'(bpsk_o1), int'(pb));
      chk($sformatf("s1_%0d.strobe", k), int'(strb1), 1);
      chk($sformatf("s1_%0d.underrun", k), int'(und1), 0);
      bpsk1 = 1'($urandom_range(0, 1));
      bits1 = 2'($urandom_range(0, 3));
    end
    valid1 = 1'b0;
    cyc;
    chk("s1.end.underrun", int'(und1), 1);
    chk("s1.end.i", int'(di1), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
